cpu_clk_sched: RTL and testbench

- Run/step controller for the multicycle CPU clock.
- Consumes the free-running clkdiv counter produced by the board clock divider, in the same clock domain.
- Issues one-cycle clock-enable pulses to the CPU:
  - RUN mode: periodically, at a rate set by a selectable clkdiv tap.
  - STEP mode: one pulse per debounced pushbutton press.
- Sits between the clock divider and the CPU's enable input; also counts issued enables for the debug display.

---
 rtl/cpu_clk_sched.sv | 143 ++++++++++++++
 tb/tb_cpu_clk_sched.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_clk_sched.sv
// Run/step clock-enable scheduler for the multicycle CPU: periodic enables from a
// clkdiv tap in RUN mode, one enable per debounced button press in STEP mode.
module cpu_clk_sched #(
   parameter int DB_CYCLES = 20,
   parameter int CNT_W     = 16
) (
   input  logic             clk,
   input  logic             RST,
   input  logic [31:0]      clkdiv,
   input  logic [4:0]       speed_sel,
   input  logic             run,
   input  logic             step_btn,
   input  logic             halt,
   output logic             cpu_ce,
   output logic             step_ack,
   output logic [CNT_W-1:0] ce_count,
   output logic [1:0]       state
);

   localparam int DB_W = $clog2(DB_CYCLES);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_RUN    = 2'b01,
      ST_STEP   = 2'b10,
      ST_HALTED = 2'b11
   } state_e;

   state_e           state_q, state_d;
   logic             cpu_ce_q, cpu_ce_d;
   logic             step_ack_q, step_ack_d;
   logic [CNT_W-1:0] ce_count_q, ce_count_d;
   logic             tap_d_q, tap_d_d;
   logic             sync1_q, sync1_d;
   logic             sync2_q, sync2_d;
   logic             btn_db_q, btn_db_d;
   logic             btn_db_dly_q, btn_db_dly_d;
   logic [DB_W-1:0]  db_cnt_q, db_cnt_d;

   logic tap;
   logic tap_rise;
   logic btn_press;

   assign tap       = clkdiv[speed_sel];
   assign tap_rise  = tap & ~tap_d_q;
   assign btn_press = btn_db_q & ~btn_db_dly_q;

   // Tap edge detector, two-flop synchroniser and debouncer.
   always_comb begin
      // NOTE: every variable written here gets a default first so no latch is inferred.
      tap_d_d      = tap;
      sync1_d      = step_btn;
      sync2_d      = sync1_q;
      btn_db_d     = btn_db_q;
      btn_db_dly_d = btn_db_q;
      db_cnt_d     = db_cnt_q;
      if (sync2_q == btn_db_q) begin
         db_cnt_d = '0;
      end else if (db_cnt_q == DB_W'(DB_CYCLES - 1)) begin
         btn_db_d = sync2_q;
         db_cnt_d = '0;
      end else begin
         db_cnt_d = db_cnt_q + DB_W'(1);
      end
   end

   // Mode FSM; halt outranks run, which outranks a button press.
   always_comb begin
      state_d    = state_q;
      cpu_ce_d   = 1'b0;
      step_ack_d = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (halt) begin
               state_d = ST_HALTED;
            end else if (run) begin
               state_d = ST_RUN;
            end else if (btn_press) begin
               state_d    = ST_STEP;
               cpu_ce_d   = 1'b1;
               step_ack_d = 1'b1;
            end
         end
         ST_RUN: begin
            if (halt) begin
               state_d = ST_HALTED;
            end else if (!run) begin
               state_d = ST_IDLE;
            end else begin
               cpu_ce_d = tap_rise;
            end
         end
         ST_STEP: begin
            // Held button keeps us here: one enable per press, run ignored until release.
            if (halt) begin
               state_d = ST_HALTED;
            end else if (!btn_db_q) begin
               state_d = ST_IDLE;
            end
         end
         ST_HALTED: begin
            if (!halt) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      ce_count_d = ce_count_q + CNT_W'(cpu_ce_d);
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      if (RST) begin
         state_q      <= ST_IDLE;
         cpu_ce_q     <= 1'b0;
         step_ack_q   <= 1'b0;
         ce_count_q   <= '0;
         tap_d_q      <= 1'b0;
         sync1_q      <= 1'b0;
         sync2_q      <= 1'b0;
         btn_db_q     <= 1'b0;
         btn_db_dly_q <= 1'b0;
         db_cnt_q     <= '0;
      end else begin
         state_q      <= state_d;
         cpu_ce_q     <= cpu_ce_d;
         step_ack_q   <= step_ack_d;
         ce_count_q   <= ce_count_d;
         tap_d_q      <= tap_d_d;
         sync1_q      <= sync1_d;
         sync2_q      <= sync2_d;
         btn_db_q     <= btn_db_d;
         btn_db_dly_q <= btn_db_dly_d;
         db_cnt_q     <= db_cnt_d;
      end
   end

   assign cpu_ce   = cpu_ce_q;
   assign step_ack = step_ack_q;
   assign ce_count = ce_count_q;
   assign state    = state_q;

endmodule

// File: tb/tb_cpu_clk_sched.sv
// Self-checking bench for cpu_clk_sched: directed scenarios plus randomized traffic,
// all compared cycle by cycle against a behavioural model of the scheduler rules.
module tb_cpu_clk_sched;

   localparam int DB = 4;
   localparam int CW = 4;
   localparam int CNT_MOD = 1 << CW;

   localparam logic [1:0] S_IDLE = 2'b00;
   localparam logic [1:0] S_RUN  = 2'b01;
   localparam logic [1:0] S_STEP = 2'b10;
   localparam logic [1:0] S_HALT = 2'b11;

   logic          clk = 1'b0;
   logic          RST = 1'b1;
   logic [31:0]   clkdiv = '0;
   logic [4:0]    speed_sel = '0;
   logic          run = 1'b0;
   logic          step_btn = 1'b0;
   logic          halt = 1'b0;
   logic          cpu_ce;
   logic          step_ack;
   logic [CW-1:0] ce_count;
   logic [1:0]    state;

   int tests = 0;
   int fails = 0;

   // Reference model: values as they should appear after the most recent edge.
   logic [1:0] m_state = S_IDLE;
   bit         m_ce, m_ack, m_tap_d, m_s1, m_s2, m_db, m_db_d;
   int         m_cnt;
   bit         hist[$];   // sync2 level seen at each of the last DB edges

   cpu_clk_sched #(.DB_CYCLES(DB), .CNT_W(CW)) dut (
      .clk       (clk),
      .RST       (RST),
      .clkdiv    (clkdiv),
      .speed_sel (speed_sel),
      .run       (run),
      .step_btn  (step_btn),
      .halt      (halt),
      .cpu_ce    (cpu_ce),
      .step_ack  (step_ack),
      .ce_count  (ce_count),
      .state     (state)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
         $error("check %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock: predict the next outputs from current inputs, clock the DUT, compare.
   task automatic tick();
      logic [1:0] n_state;
      bit n_ce, n_ack, tap, rise, press, stable;
      n_state = m_state;
      n_ce    = 0;
      n_ack   = 0;
      tap     = clkdiv[speed_sel];
      rise    = tap && !m_tap_d;
      press   = m_db && !m_db_d;
      if (RST) begin
         n_state = S_IDLE;
         hist.delete();
      end else begin
         case (m_state)
            S_IDLE:
               if (halt) n_state = S_HALT;
               else if (run) n_state = S_RUN;
               else if (press) begin n_state = S_STEP; n_ce = 1; n_ack = 1; end
            S_RUN:
               if (halt) n_state = S_HALT;
               else if (!run) n_state = S_IDLE;
               else n_ce = rise;
            S_STEP:
               if (halt) n_state = S_HALT;
               else if (!m_db) n_state = S_IDLE;
            default:
               if (!halt) n_state = S_IDLE;
         endcase
         hist.push_back(m_s2);
         if (hist.size() > DB) void'(hist.pop_front());
      end
      // A new level is accepted once DB consecutive samples all disagree with it.
      stable = !RST && (hist.size() == DB);
      foreach (hist[i]) if (hist[i] == m_db) stable = 0;

      @(posedge clk);
      #1;
      clkdiv = clkdiv + 1;
      if (RST) begin
         m_ce = 0; m_ack = 0; m_cnt = 0; m_tap_d = 0;
         m_s1 = 0; m_s2 = 0; m_db = 0; m_db_d = 0;
      end else begin
         m_cnt   = (m_cnt + int'(n_ce)) % CNT_MOD;
         m_ce    = n_ce;
         m_ack   = n_ack;
         m_tap_d = tap;
         m_db_d  = m_db;
         if (stable) m_db = !m_db;
         m_s2    = m_s1;
         m_s1    = step_btn;
      end
      m_state = n_state;
      check("cpu_ce", 32'(cpu_ce), 32'(m_ce));
      check("step_ack", 32'(step_ack), 32'(m_ack));
      check("ce_count", 32'(ce_count), 32'(m_cnt));
      check("state", 32'(state), 32'(m_state));
   endtask

   initial begin
      int pulses, acks, bad, last, c0;
      bit found;

      // Reset, then idle with all inputs low.
      RST = 1'b1;
      tick();
      tick();
      RST = 1'b0;
      for (int i = 0; i < 100; i++) tick();
      check("idle_state", 32'(state), 32'(S_IDLE));
      check("idle_count", 32'(ce_count), 0);

      // RUN rate with tap bit 2: one enable every 8 cycles.
      run = 1'b1;
      speed_sel = 5'd2;
      c0 = int'(ce_count);
      pulses = 0; acks = 0; bad = 0; last = -1;
      for (int i = 0; i < 200; i++) begin
         tick();
         if (cpu_ce) begin
            if (last >= 0 && i - last != 8) bad++;
            last = i;
            pulses++;
         end
         if (step_ack) acks++;
      end
      check("run_gap_errors", 32'(bad), 0);
      check("run_pulse_total", 32'(pulses >= 24 && pulses <= 26), 1);
      check("run_count", 32'(ce_count), 32'((c0 + pulses) % CNT_MOD));
      check("run_acks", 32'(acks), 0);

      // Bouncy press 1/0/1 then held from edge k: enable after edge k+2+DB.
      run = 1'b0;
      tick();
      tick();
      c0 = int'(ce_count);
      step_btn = 1'b1; tick();
      step_btn = 1'b0; tick();
      step_btn = 1'b1;
      for (int i = 0; i <= 8; i++) begin
         tick();
         check($sformatf("step_ce_k%0d", i), 32'(cpu_ce), 32'(i == DB + 2));
         check($sformatf("step_ack_k%0d", i), 32'(step_ack), 32'(i == DB + 2));
      end
      for (int i = 0; i < 10; i++) tick();
      check("step_held_state", 32'(state), 32'(S_STEP));
      step_btn = 1'b0;
      for (int i = 0; i < 20 && state != S_IDLE; i++) tick();
      check("step_release_idle", 32'(state), 32'(S_IDLE));
      check("step_count", 32'(ce_count), 32'((c0 + 1) % CNT_MOD));

      // Glitch shorter than the debounce window is filtered.
      pulses = 0;
      step_btn = 1'b1;
      for (int i = 0; i < 3; i++) begin tick(); if (cpu_ce) pulses++; end
      step_btn = 1'b0;
      for (int i = 0; i < 20; i++) begin tick(); if (cpu_ce) pulses++; end
      check("glitch_no_ce", 32'(pulses), 0);
      check("glitch_state", 32'(state), 32'(S_IDLE));

      // Halt raised in the same cycle as a tap rise wins.
      run = 1'b1;
      speed_sel = 5'd2;
      found = 0;
      for (int i = 0; i < 40 && !found; i++) begin
         if (m_state == S_RUN && clkdiv[speed_sel] && !m_tap_d) found = 1;
         else tick();
      end
      check("halt_tap_found", 32'(found), 1);
      halt = 1'b1;
      tick();
      check("halt_no_ce", 32'(cpu_ce), 0);
      check("halt_state", 32'(state), 32'(S_HALT));
      halt = 1'b0;
      tick();
      check("unhalt_idle", 32'(state), 32'(S_IDLE));
      tick();
      check("unhalt_run", 32'(state), 32'(S_RUN));

      // Counter wrap after 17 enables, then reset in the middle of STEP.
      RST = 1'b1;
      tick();
      RST = 1'b0;
      run = 1'b1;
      speed_sel = 5'd0;
      pulses = 0;
      for (int i = 0; i < 200 && pulses < 17; i++) begin tick(); if (cpu_ce) pulses++; end
      run = 1'b0;
      tick();
      check("wrap_pulses", 32'(pulses), 17);
      check("wrap_count", 32'(ce_count), 1);
      step_btn = 1'b1;
      for (int i = 0; i < 20 && state != S_STEP; i++) tick();
      check("midstep_reached", 32'(state), 32'(S_STEP));
      RST = 1'b1;
      tick();
      check("midstep_rst_state", 32'(state), 32'(S_IDLE));
      check("midstep_rst_count", 32'(ce_count), 0);
      check("midstep_rst_ce", 32'(cpu_ce), 0);
      RST = 1'b0;
      step_btn = 1'b0;

      // Randomized traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(99) < 3) run = ~run;
         if ($urandom_range(99) < 2) halt = ~halt;
         if ($urandom_range(99) < 4) speed_sel = 5'($urandom_range(3));
         if ($urandom_range(99) < 12) step_btn = ~step_btn;
         RST = ($urandom_range(399) == 0);
         tick();
      end
      RST = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
